mc_datapath_v3: RTL and testbench
=================================

// Module: mc_datapath_v3
// PURPOSE
//  Parametrised multicycle MIPS-style datapath: PC, IR, MDR, A, B and ALUOut registers, register file, operand muxes.
//  Sits between the multicycle control FSM and unified instruction/data memory. The ALU is external.
//  Adds to the previous datapath: a memory ready/stall handshake, a selectable register count, and a 3-way PC source.
//  Also adds a debug override port that takes the memory bus and freezes all architectural state.
// PARAMETERS
//  BIT_WIDTH   32          datapath width; legal values 32 or 64
//  REG_COUNT   32          architectural registers; power of 2, 2..32; RA_W = $clog2(REG_COUNT)
//  RESET_PC    0           PC value loaded on reset
// PORTS
//  clk               in   1          rising-edge clock
//  reset             in   1          synchronous, active-high
//  pc_en             in   1          PC write enable (control decides branch/jump)
//  ir_write_en       in   1          latch mem_rdata into IR
//  reg_write_en      in   1          register-file write enable
//  iord_sel          in   1          mem_addr: 0 = PC, 1 = ALUOut
//  mem_to_reg_sel    in   1          writeback data: 0 = ALUOut, 1 = MDR
//  reg_dst_sel       in   1          writeback address: 0 = IR[20:16], 1 = IR[15:11]
//  alu_a_src_sel     in   1          alu_src_a: 0 = PC, 1 = A
//  alu_b_src_sel     in   2          alu_src_b: 00 = B, 01 = 4, 10 = sext(imm), 11 = sext(imm)<<2
//  pc_src_sel        in   2          next PC: 00 = alu_result, 01 = ALUOut, 10 = jump target, 11 = RESET_PC
//  mem_read_en       in   1          control requests a memory read this cycle
//  mem_write_en      in   1          control requests a memory write this cycle
//  alu_result        in   BIT_WIDTH  combinational result from the external ALU
//  alu_src_a         out  BIT_WIDTH  ALU operand A
//  alu_src_b         out  BIT_WIDTH  ALU operand B
//  mem_addr          out  BIT_WIDTH  memory address
//  mem_wdata         out  BIT_WIDTH  memory write data (register B)
//  mem_we            out  1          memory write strobe
//  mem_re            out  1          memory read strobe
//  mem_rdata         in   BIT_WIDTH  memory read data; valid when mem_ready = 1
//  mem_ready         in   1          memory completes the current access this cycle
//  stall             out  1          (mem_re | mem_we) & ~mem_ready; control must hold its state
//  instr             out  BIT_WIDTH  current IR contents, for the control FSM
//  dbg_en            in   1          debug override active
//  dbg_we            in   1          debug write (valid only while dbg_en = 1)
//  dbg_addr          in   BIT_WIDTH  debug address
//  dbg_wdata         in   BIT_WIDTH  debug write data
//  dbg_rdata         out  BIT_WIDTH  mem_rdata, forwarded to the debug host
// BEHAVIOUR
//  - Reset (sync, priority over everything): PC = RESET_PC; IR, MDR, A, B, ALUOut = 0; all registers = 0.
//    The next cycle therefore shows mem_we = mem_re = stall = 0 as long as the control inputs are low.
//  - A and B latch the regfile reads of IR[25:21] and IR[20:16] every non-frozen cycle.
//    ALUOut latches alu_result every non-frozen cycle. Register-address fields are truncated to RA_W bits.
//  - frozen = stall | dbg_en. While frozen, PC, IR, MDR, A, B, ALUOut and the register file all hold.
//  - IR loads mem_rdata when ir_write_en & mem_ready & ~dbg_en. MDR loads mem_rdata when mem_ready & ~dbg_en.
//  - The register file reads combinationally and writes on the clock edge. Register 0 reads 0 and ignores writes.
//  - sext(imm) = IR[15:0] sign-extended to BIT_WIDTH.
//  - Jump target = {PC[BIT_WIDTH-1:28], IR[25:0], 2'b00}. All adds are modulo 2^BIT_WIDTH and wrap silently.
//  - Memory bus in normal mode: mem_addr = iord_sel ? ALUOut : PC; mem_re = mem_read_en; mem_we = mem_write_en.
//    Asserting mem_read_en and mem_write_en together is illegal; when it happens, mem_we wins and mem_re = 0.
//  - Memory bus in debug mode (dbg_en = 1): mem_addr = dbg_addr; mem_wdata = dbg_wdata; mem_we = dbg_we; mem_re = ~dbg_we.
//    stall is forced to 0 in debug mode.
//  - Handshake: a request stays asserted, with a stable address, until the cycle in which mem_ready = 1.
//    That cycle completes the access, and the frozen registers update at its edge.
//  - Reset mid-stall: the access is abandoned and mem_re/mem_we drop the cycle after reset.
//  - Dropping dbg_en mid-access: normal mode resumes the next cycle and prior state is untouched.
// STRUCTURE
//  - Package mc_dp_pkg: localparams for the ALUB_*, PCSRC_* and IORD_* encodings and the IR field bit positions.
//  - Sub-module mc_regfile #(BIT_WIDTH, REG_COUNT): 2 read ports, 1 write port, r0 hardwired to 0.
//  - Everything else is the top: registers, muxes, handshake and freeze logic.
// TESTING
//  1. reset = 1 for 2 cycles with RESET_PC = 'h100 -> PC = 'h100, instr = 0, stall = 0, mem_we = 0.
//  2. Fetch: iord_sel = 0, mem_read_en = 1, ir_write_en = 1, mem_ready low for 3 cycles -> stall = 1 for 3 cycles, PC held.
//     Then mem_ready = 1 with mem_rdata = 'h8C220004 -> IR = 'h8C220004.
//  3. With PC = 'h100: alu_a_src_sel = 0, alu_b_src_sel = 01 -> alu_src_b = 4.
//     Drive alu_result = 'h104 with pc_en = 1, pc_src_sel = 00 -> PC = 'h104.
//  4. IR imm = 'hFFFC, alu_b_src_sel = 11 -> alu_src_b = 'hFFFFFFF0.
//     Writeback to r0 with reg_write_en = 1 and data 'h55 -> r0 still reads 0.
//  5. dbg_en = 1, dbg_we = 1, dbg_addr = 'h40, dbg_wdata = 'hDEAD while pc_en = 1 -> mem_we = 1, mem_addr = 'h40.
//     PC, IR and the register file are unchanged.
//  6. Assert reset during a 5-cycle stalled load -> the cycle after reset, mem_re = 0, PC = RESET_PC, MDR = 0.

Source files
------------

// File: rtl/mc_dp_pkg.sv
// Shared encodings for the multicycle datapath.
// Mux selects and IR field positions.
package mc_dp_pkg;

  localparam logic [1:0] ALUB_B      = 2'b00;
  localparam logic [1:0] ALUB_FOUR   = 2'b01;
  localparam logic [1:0] ALUB_IMM    = 2'b10;
  localparam logic [1:0] ALUB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_RESET  = 2'b11;

  localparam logic IORD_PC     = 1'b0;
  localparam logic IORD_ALUOUT = 1'b1;

  localparam int IR_RS_LO  = 21;
  localparam int IR_RT_LO  = 16;
  localparam int IR_RD_LO  = 11;
  localparam int IR_IMM_HI = 15;
  localparam int IR_JMP_HI = 25;
  localparam int JMP_PC_LO = 28;

endpackage

// File: rtl/mc_regfile.sv
// Two-read, one-write register file.
// Register 0 reads zero and drops writes.
module mc_regfile
  import mc_dp_pkg::*;
#(
  parameter int BIT_WIDTH = 32,
  parameter int REG_COUNT = 32,
  localparam int RA_W = $clog2(REG_COUNT)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 we_i,
  input  logic [RA_W-1:0]      waddr_i,
  input  logic [BIT_WIDTH-1:0] wdata_i,
  input  logic [RA_W-1:0]      raddr1_i,
  input  logic [RA_W-1:0]      raddr2_i,
  output logic [BIT_WIDTH-1:0] rdata1_o,
  output logic [BIT_WIDTH-1:0] rdata2_o
);

  logic [BIT_WIDTH-1:0] regs_q [REG_COUNT];

  // Clear all on reset; write only non-zero targets.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i && (waddr_i != '0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  // Combinational reads with r0 forced to zero.
  always_comb begin
    rdata1_o = (raddr1_i == '0) ? '0 : regs_q[raddr1_i];
    rdata2_o = (raddr2_i == '0) ? '0 : regs_q[raddr2_i];
  end

endmodule

// File: rtl/mc_datapath_v3.sv
// Multicycle MIPS-style datapath with memory
// stall handshake and debug bus override.
module mc_datapath_v3
  import mc_dp_pkg::*;
#(
  parameter int BIT_WIDTH = 32,
  parameter int REG_COUNT = 32,
  parameter logic [BIT_WIDTH-1:0] RESET_PC = '0,
  localparam int RA_W = $clog2(REG_COUNT)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pc_en,
  input  logic                 ir_write_en,
  input  logic                 reg_write_en,
  input  logic                 iord_sel,
  input  logic                 mem_to_reg_sel,
  input  logic                 reg_dst_sel,
  input  logic                 alu_a_src_sel,
  input  logic [1:0]           alu_b_src_sel,
  input  logic [1:0]           pc_src_sel,
  input  logic                 mem_read_en,
  input  logic                 mem_write_en,
  input  logic [BIT_WIDTH-1:0] alu_result,
  output logic [BIT_WIDTH-1:0] alu_src_a,
  output logic [BIT_WIDTH-1:0] alu_src_b,
  output logic [BIT_WIDTH-1:0] mem_addr,
  output logic [BIT_WIDTH-1:0] mem_wdata,
  output logic                 mem_we,
  output logic                 mem_re,
  input  logic [BIT_WIDTH-1:0] mem_rdata,
  input  logic                 mem_ready,
  output logic                 stall,
  output logic [BIT_WIDTH-1:0] instr,
  input  logic                 dbg_en,
  input  logic                 dbg_we,
  input  logic [BIT_WIDTH-1:0] dbg_addr,
  input  logic [BIT_WIDTH-1:0] dbg_wdata,
  output logic [BIT_WIDTH-1:0] dbg_rdata
);

  logic [BIT_WIDTH-1:0] pc_q, pc_d;
  logic [BIT_WIDTH-1:0] ir_q, ir_d;
  logic [BIT_WIDTH-1:0] mdr_q, mdr_d;
  logic [BIT_WIDTH-1:0] a_q, a_d;
  logic [BIT_WIDTH-1:0] b_q, b_d;
  logic [BIT_WIDTH-1:0] aluout_q, aluout_d;

  logic [BIT_WIDTH-1:0] rf_rd1, rf_rd2;
  logic [BIT_WIDTH-1:0] wb_data;
  logic [RA_W-1:0]      wb_addr;
  logic                 rf_we;

  logic [BIT_WIDTH-1:0] imm_ext;
  logic [BIT_WIDTH-1:0] jump_tgt;
  logic [BIT_WIDTH-1:0] four;
  logic                 frozen;
  logic                 mem_take;

  assign four     = {{(BIT_WIDTH-3){1'b0}}, 3'd4};
  assign imm_ext  = {{(BIT_WIDTH-16){ir_q[IR_IMM_HI]}},
                     ir_q[IR_IMM_HI:0]};
  assign jump_tgt = {pc_q[BIT_WIDTH-1:JMP_PC_LO],
                     ir_q[IR_JMP_HI:0], 2'b00};

  assign instr     = ir_q;
  assign dbg_rdata = mem_rdata;

  // Memory bus: debug host owns it while dbg_en is high.
  always_comb begin
    mem_addr  = (iord_sel == IORD_ALUOUT) ? aluout_q : pc_q;
    mem_wdata = b_q;
    mem_we    = mem_write_en;
    mem_re    = mem_read_en & ~mem_write_en;
    stall     = (mem_read_en | mem_write_en) & ~mem_ready;
    if (dbg_en) begin
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
      mem_we    = dbg_we;
      mem_re    = ~dbg_we;
      stall     = 1'b0;
    end
  end

  assign frozen   = stall | dbg_en;
  assign mem_take = mem_ready & ~dbg_en;

  // ALU operand selection.
  always_comb begin
    alu_src_a = alu_a_src_sel ? a_q : pc_q;
    alu_src_b = b_q;
    unique case (alu_b_src_sel)
      ALUB_B:      alu_src_b = b_q;
      ALUB_FOUR:   alu_src_b = four;
      ALUB_IMM:    alu_src_b = imm_ext;
      ALUB_IMM_SH: alu_src_b = imm_ext << 2;
      default:     alu_src_b = b_q;
    endcase
  end

  // Writeback address/data and gated write enable.
  always_comb begin
    wb_addr = reg_dst_sel ? ir_q[IR_RD_LO +: RA_W]
                          : ir_q[IR_RT_LO +: RA_W];
    wb_data = mem_to_reg_sel ? mdr_q : aluout_q;
    rf_we   = reg_write_en & ~frozen;
  end

  // Next-state for architectural registers under freeze.
  always_comb begin
    pc_d     = pc_q;
    ir_d     = ir_q;
    mdr_d    = mdr_q;
    a_d      = a_q;
    b_d      = b_q;
    aluout_d = aluout_q;
    if (!frozen) begin
      a_d      = rf_rd1;
      b_d      = rf_rd2;
      aluout_d = alu_result;
      if (pc_en) begin
        unique case (pc_src_sel)
          PCSRC_ALU:    pc_d = alu_result;
          PCSRC_ALUOUT: pc_d = aluout_q;
          PCSRC_JUMP:   pc_d = jump_tgt;
          PCSRC_RESET:  pc_d = RESET_PC;
          default:      pc_d = pc_q;
        endcase
      end
    end
    if (mem_take) begin
      mdr_d = mem_rdata;
      if (ir_write_en) begin
        ir_d = mem_rdata;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q     <= RESET_PC;
      ir_q     <= '0;
      mdr_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      aluout_q <= '0;
    end else begin
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      mdr_q    <= mdr_d;
      a_q      <= a_d;
      b_q      <= b_d;
      aluout_q <= aluout_d;
    end
  end

  mc_regfile #(
    .BIT_WIDTH(BIT_WIDTH),
    .REG_COUNT(REG_COUNT)
  ) u_rf (
    .clk      (clk),
    .reset    (reset),
    .we_i     (rf_we),
    .waddr_i  (wb_addr),
    .wdata_i  (wb_data),
    .raddr1_i (ir_q[IR_RS_LO +: RA_W]),
    .raddr2_i (ir_q[IR_RT_LO +: RA_W]),
    .rdata1_o (rf_rd1),
    .rdata2_o (rf_rd2)
  );

endmodule

// File: tb/tb_mc_datapath_v3.sv
// Scoreboard bench for mc_datapath_v3 with a
// behavioural model and randomized control.
module tb_mc_datapath_v3;

  localparam int BW = 32;
  localparam int RC = 16;
  localparam logic [31:0] RPC = 32'h100;

  logic clk = 1'b0;
  logic reset;
  logic pc_en, ir_write_en, reg_write_en, iord_sel;
  logic mem_to_reg_sel, reg_dst_sel, alu_a_src_sel;
  logic [1:0] alu_b_src_sel, pc_src_sel;
  logic mem_read_en, mem_write_en;
  logic [31:0] alu_result, mem_rdata;
  logic mem_ready, dbg_en, dbg_we;
  logic [31:0] dbg_addr, dbg_wdata;
  logic [31:0] alu_src_a, alu_src_b, mem_addr, mem_wdata;
  logic [31:0] instr, dbg_rdata;
  logic mem_we, mem_re, stall;

  always #5 clk = ~clk;

  mc_datapath_v3 #(
    .BIT_WIDTH(BW), .REG_COUNT(RC), .RESET_PC(RPC)
  ) dut (
    .clk(clk), .reset(reset), .pc_en(pc_en),
    .ir_write_en(ir_write_en),
    .reg_write_en(reg_write_en), .iord_sel(iord_sel),
    .mem_to_reg_sel(mem_to_reg_sel),
    .reg_dst_sel(reg_dst_sel),
    .alu_a_src_sel(alu_a_src_sel),
    .alu_b_src_sel(alu_b_src_sel),
    .pc_src_sel(pc_src_sel),
    .mem_read_en(mem_read_en),
    .mem_write_en(mem_write_en),
    .alu_result(alu_result),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .stall(stall), .instr(instr),
    .dbg_en(dbg_en), .dbg_we(dbg_we),
    .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_rdata(dbg_rdata)
  );

  typedef struct packed {
    logic [31:0] a, b, addr, wdata, ins, drd;
    logic we, re, stl;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;

  logic [31:0] m_pc, m_ir, m_mdr, m_a, m_b, m_alu;
  logic [31:0] m_rf [RC];

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] sext(logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    logic [31:0] se;
    se = sext(m_ir[15:0]);
    e.a = alu_a_src_sel ? m_a : m_pc;
    case (alu_b_src_sel)
      2'd0: e.b = m_b;
      2'd1: e.b = 32'd4;
      2'd2: e.b = se;
      default: e.b = se * 4;
    endcase
    e.ins = m_ir;
    e.drd = mem_rdata;
    if (dbg_en) begin
      e.addr = dbg_addr;
      e.wdata = dbg_wdata;
      e.we = dbg_we;
      e.re = !dbg_we;
      e.stl = 1'b0;
    end else begin
      e.addr = iord_sel ? m_alu : m_pc;
      e.wdata = m_b;
      e.we = mem_write_en;
      e.re = mem_read_en && !mem_write_en;
      e.stl = (mem_read_en || mem_write_en) && !mem_ready;
    end
    return e;
  endfunction

  task automatic model_step();
    logic frz;
    int rs, rt, wa;
    logic [31:0] na, nb, npc;
    if (reset) begin
      m_pc = RPC;
      m_ir = 0; m_mdr = 0; m_a = 0; m_b = 0; m_alu = 0;
      for (int i = 0; i < RC; i++) m_rf[i] = 0;
      return;
    end
    frz = dbg_en ||
          ((mem_read_en || mem_write_en) && !mem_ready);
    if (!frz) begin
      rs = int'(m_ir[25:21]) % RC;
      rt = int'(m_ir[20:16]) % RC;
      na = m_rf[rs];
      nb = m_rf[rt];
      npc = m_pc;
      if (pc_en) begin
        case (pc_src_sel)
          2'd0: npc = alu_result;
          2'd1: npc = m_alu;
          2'd2: npc = {m_pc[31:28], m_ir[25:0], 2'b00};
          default: npc = RPC;
        endcase
      end
      if (reg_write_en) begin
        wa = int'(reg_dst_sel ? m_ir[15:11] : m_ir[20:16]) % RC;
        if (wa != 0) m_rf[wa] = mem_to_reg_sel ? m_mdr : m_alu;
      end
      m_a = na;
      m_b = nb;
      m_pc = npc;
      m_alu = alu_result;
    end
    if (mem_ready && !dbg_en) begin
      m_mdr = mem_rdata;
      if (ir_write_en) m_ir = mem_rdata;
    end
  endtask

  task automatic apply();
    q.push_back(model_out());
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle();
    reset = 0; pc_en = 0; ir_write_en = 0;
    reg_write_en = 0; iord_sel = 0;
    mem_to_reg_sel = 0; reg_dst_sel = 0;
    alu_a_src_sel = 0; alu_b_src_sel = 0;
    pc_src_sel = 0; mem_read_en = 0;
    mem_write_en = 0; alu_result = 0;
    mem_rdata = 0; mem_ready = 0;
    dbg_en = 0; dbg_we = 0;
    dbg_addr = 0; dbg_wdata = 0;
  endtask

  // Monitor: compare every presented output cycle.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("sb_alu_a", alu_src_a, e.a);
      chk("sb_alu_b", alu_src_b, e.b);
      chk("sb_addr", mem_addr, e.addr);
      chk("sb_wdata", mem_wdata, e.wdata);
      chk("sb_instr", instr, e.ins);
      chk("sb_dbg_rdata", dbg_rdata, e.drd);
      chk("sb_we", {31'd0, mem_we}, {31'd0, e.we});
      chk("sb_re", {31'd0, mem_re}, {31'd0, e.re});
      chk("sb_stall", {31'd0, stall}, {31'd0, e.stl});
    end
  end

  initial begin
    idle();
    reset = 1;
    repeat (2) begin
      @(posedge clk);
      model_step();
    end
    #1;

    idle(); apply(); #3;
    chk("rst_pc", mem_addr, 32'h100);
    chk("rst_instr", instr, 32'h0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_we", {31'd0, mem_we}, 32'd0);
    tick();

    mem_read_en = 1; ir_write_en = 1;
    repeat (3) begin
      apply(); #3;
      chk("fetch_stall", {31'd0, stall}, 32'd1);
      chk("fetch_pc_held", mem_addr, 32'h100);
      tick();
    end
    mem_ready = 1; mem_rdata = 32'h8C220004;
    apply(); #3;
    chk("fetch_done_stall", {31'd0, stall}, 32'd0);
    tick();

    idle();
    alu_b_src_sel = 2'b01; pc_en = 1;
    pc_src_sel = 2'b00; alu_result = 32'h104;
    apply(); #3;
    chk("ir_loaded", instr, 32'h8C220004);
    chk("srcb_four", alu_src_b, 32'd4);
    chk("srca_pc", alu_src_a, 32'h100);
    tick();
    idle(); apply(); #3;
    chk("pc_inc", mem_addr, 32'h104);
    tick();

    mem_read_en = 1; ir_write_en = 1; mem_ready = 1;
    mem_rdata = 32'h2000FFFC; alu_result = 32'h55;
    apply(); tick();
    idle();
    alu_b_src_sel = 2'b11; reg_write_en = 1;
    apply(); #3;
    chk("imm_sh", alu_src_b, 32'hFFFFFFF0);
    tick();
    idle(); apply(); tick();
    alu_a_src_sel = 1;
    apply(); #3;
    chk("r0_zero", alu_src_a, 32'h0);
    tick();

    idle();
    dbg_en = 1; dbg_we = 1; dbg_addr = 32'h40;
    dbg_wdata = 32'hDEAD; pc_en = 1;
    alu_result = 32'h999; ir_write_en = 1;
    mem_ready = 1; mem_rdata = 32'h12345678;
    reg_write_en = 1;
    apply(); #3;
    chk("dbg_we", {31'd0, mem_we}, 32'd1);
    chk("dbg_addr", mem_addr, 32'h40);
    chk("dbg_wdata", mem_wdata, 32'hDEAD);
    chk("dbg_re", {31'd0, mem_re}, 32'd0);
    tick();
    idle(); apply(); #3;
    chk("dbg_ir_hold", instr, 32'h2000FFFC);
    chk("dbg_pc_hold", mem_addr, 32'h104);
    tick();

    iord_sel = 1; mem_read_en = 1;
    repeat (2) begin
      apply(); #3;
      chk("ld_stall", {31'd0, stall}, 32'd1);
      tick();
    end
    reset = 1;
    apply(); tick();
    idle(); apply(); #3;
    chk("rst_mid_re", {31'd0, mem_re}, 32'd0);
    chk("rst_mid_pc", mem_addr, 32'h100);
    chk("rst_mid_ir", instr, 32'h0);
    tick();

    for (int n = 0; n < 600; n++) begin
      reset = ($urandom_range(0, 59) == 0);
      pc_en = 1'($urandom);
      ir_write_en = 1'($urandom);
      reg_write_en = 1'($urandom);
      iord_sel = 1'($urandom);
      mem_to_reg_sel = 1'($urandom);
      reg_dst_sel = 1'($urandom);
      alu_a_src_sel = 1'($urandom);
      alu_b_src_sel = 2'($urandom);
      pc_src_sel = 2'($urandom);
      mem_read_en = ($urandom_range(0, 2) == 0);
      mem_write_en = ($urandom_range(0, 4) == 0);
      alu_result = $urandom;
      mem_rdata = $urandom;
      mem_ready = ($urandom_range(0, 2) != 0);
      dbg_en = ($urandom_range(0, 7) == 0);
      dbg_we = 1'($urandom);
      dbg_addr = $urandom;
      dbg_wdata = $urandom;
      apply();
      tick();
    end

    idle();
    @(negedge clk);
    #1;
    chk("sb_drained", q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
